// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and IF/ID record for the fetch stage
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [XLEN-1:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - program counter with redirect/stall/halt priority and RUN/HALT state
module fetch_pc_gen
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_hit,
  input  logic            fault_hit,
  input  logic            fault_lock,
  output logic [XLEN-1:0] pc,
  output logic            halted
);

  fetch_state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= ST_RUN;
    end else if (redirect_valid) begin
      // A redirect abandons a wrong-path halt, but never a bounds fault.
      pc    <= redirect_pc;
      state <= fault_lock ? ST_HALT : ST_RUN;
    end else if (!stall && state == ST_RUN) begin
      if (fault_hit || halt_hit) begin
        state <= ST_HALT;
      end else begin
        pc <= pc + 32'd4;
      end
    end
  end

  assign halted = (state == ST_HALT);

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage with IF/ID register; optional FETCH_BOUNDS_EN fault check
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [XLEN-1:0]   rom_instr,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              if_id_valid,
  output logic [XLEN-1:0]   if_id_pc,
  output logic [XLEN-1:0]   if_id_pc4,
  output logic [XLEN-1:0]   if_id_instr,
  output logic              halted,
  output logic              fetch_fault
);

  logic [XLEN-1:0] pc;
  logic            halt_hit;
  logic            fault_hit;
  logic            fault_q;
  if_id_t          if_id;

  assign rom_addr = pc[ADDR_W+1:2];
  assign halt_hit = (rom_instr == HALT_INSTR);

`ifdef FETCH_BOUNDS_EN
  logic bounds_bad;
  assign bounds_bad = (pc[1:0] != 2'b00) || (pc[XLEN-1:ADDR_W+2] != '0);
  assign fault_hit  = bounds_bad && !halted && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (!redirect_valid && fault_hit) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign fault_hit = 1'b0;
  assign fault_q   = 1'b0;
`endif

  fetch_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_hit       (halt_hit),
    .fault_hit      (fault_hit),
    .fault_lock     (fault_q),
    .pc             (pc),
    .halted         (halted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id.valid <= 1'b0;
      if_id.pc    <= '0;
      if_id.pc4   <= '0;
      if_id.instr <= NOP_INSTR;
    end else if (redirect_valid) begin
      if_id.valid <= 1'b0;
      if_id.instr <= NOP_INSTR;
    end else if (!stall) begin
      if (halted || fault_hit) begin
        if_id.valid <= 1'b0;
        if_id.instr <= NOP_INSTR;
      end else begin
        // The halt word itself retires as a valid instruction.
        if_id.valid <= 1'b1;
        if_id.pc    <= pc;
        if_id.pc4   <= pc + 32'd4;
        if_id.instr <= rom_instr;
      end
    end
  end

  assign if_id_valid = if_id.valid;
  assign if_id_pc    = if_id.pc;
  assign if_id_pc4   = if_id.pc4;
  assign if_id_instr = if_id.instr;
  assign fetch_fault = fault_q;

endmodule
